bellek_asamasi: RTL and testbench
=================================

Name: bellek_asamasi

Overview:
- Memory-access stage between the ALU (amb) and write-back (geriyazma) of the kutu pipeline.
- Takes the ALU result as the effective address, with store data and funct3. Runs one outstanding request/response transaction to data memory.
- Aligns and extends load data, and stalls upstream while busy.
- Non-memory instructions pass the ALU result through with one cycle of latency.

Parameters:
ZAMAN_ASIMI, 255, max cycles in ISTEK+YANIT before abort; 0 disables timeout

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
gecerli_i  input  1  instruction valid from ALU stage
yukle_i  input  1  instruction is a load
sakla_i  input  1  instruction is a store
funct3_i  input  3  RV32I funct3 (width/sign)
adres_i  input  32  ALU result: effective address or pass-through result
veri_i  input  32  store data (rs2)
hedef_i  input  5  destination register rd
durdur_o  output  1  stall: upstream holds all inputs while 1
bellek_istek_o  output  1  memory request valid
bellek_hazir_i  input  1  memory accepts request this cycle
bellek_yaz_o  output  1  1 = write, 0 = read
bellek_adres_o  output  32  word-aligned address {adres[31:2],2'b00}
bellek_maske_o  output  4  byte write enables
bellek_veri_o  output  32  lane-replicated store data
bellek_yanit_gecerli_i  input  1  read data valid
bellek_veri_i  input  32  read data word
sonuc_gecerli_o  output  1  write-back valid (one-cycle pulse)
sonuc_o  output  32  write-back value
hedef_o  output  5  write-back rd
hata_o  output  1  one-cycle pulse: misaligned, illegal or timed-out access

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to BOSTA.
  - All outputs are 0.
  - Timeout counter is 0.
- States and transitions:
  - BOSTA: accept when gecerli_i=1.
    - Memory op, legal and aligned: latch address/data/funct3/rd, go to ISTEK.
    - Non-memory op: on the next cycle sonuc_o=adres_i, hedef_o=hedef_i, sonuc_gecerli_o=1; stay in BOSTA.
  - ISTEK: bellek_istek_o=1 with stable address/mask/data until bellek_hazir_i=1.
    - Store accepted: go to BOSTA; no write-back.
    - Load accepted: go to YANIT.
  - YANIT: wait for bellek_yanit_gecerli_i=1.
    - Then register the aligned result; sonuc_gecerli_o=1 on the next cycle; go to BOSTA.
- Stall:
  - durdur_o = (state != BOSTA), decoded from the state register.
  - A held instruction is accepted in the cycle the state returns to BOSTA.
- Memory contract:
  - A response arrives at least 1 cycle after request acceptance.
  - bellek_yanit_gecerli_i is ignored outside YANIT; stale responses after reset are dropped.
- Legality (checked at accept):
  - Loads: funct3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: funct3 in {000 SB, 001 SH, 010 SW}.
  - yukle_i & sakla_i together is illegal.
  - Halfword requires adres[0]=0; word requires adres[1:0]=0.
  - On violation: no memory access, hata_o pulses on the next cycle, no sonuc_gecerli_o, stay in BOSTA.
- Store mask, with off=adres[1:0]:
  - SB: 4'b0001<<off, data {4{veri[7:0]}}.
  - SH: 4'b0011<<off, data {2{veri[15:0]}}.
  - SW: 4'b1111, data veri.
  - For reads, bellek_maske_o=0.
- Load alignment:
  - Select byte lane off, or halfword lane off[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- Loads to rd=x0 are still performed and written back with hedef_o=0; geriyazma discards them.
- Timeout (ZAMAN_ASIMI>0):
  - Counter clears on entering ISTEK and increments each cycle in ISTEK/YANIT.
  - When count == ZAMAN_ASIMI: drop bellek_istek_o, pulse hata_o, go to BOSTA.
- Latency:
  - Non-memory: 1 cycle.
  - Load with immediate hazir and 1-cycle response: accept T0, request T1, response T2, sonuc_gecerli_o T3.
  - Store: accept T0, accepted T1, durdur_o low T2.

Decomposition:
- Package kutu_paket holds:
  - funct3 load/store constants.
  - The state enum {BOSTA, ISTEK, YANIT}.
  - A width localparam of 32.
- One sub-module: yukleme_hizalayici. It is combinational: funct3, offset and the read word in; the extended 32-bit result out.

Test Plan:
- Non-memory op: gecerli_i=1, adres_i=0x0000_1234, hedef_i=5 -> next cycle sonuc_gecerli_o=1, sonuc_o=0x0000_1234, hedef_o=5, durdur_o=0 throughout.
- LB at 0x103, read word 0x80FF_0000, hazir immediate, response +1 -> sonuc_o=0xFFFF_FF80 at T3; LBU -> 0x0000_0080; durdur_o=1 on T1..T2.
- SH at 0x202, veri_i=0xAAAA_BEEF -> bellek_adres_o=0x200, maske=4'b1100, bellek_veri_o=0xBEEF_BEEF, bellek_yaz_o=1; no sonuc_gecerli_o.
- LW at 0x0000_0006 -> no bellek_istek_o, hata_o pulse next cycle; funct3=011 load -> same response.
- bellek_hazir_i held 0 with ZAMAN_ASIMI=4 -> hata_o pulses, bellek_istek_o drops, state BOSTA; with hazir held 3 cycles then 1 -> normal completion.
- rst_i low while in YANIT -> all outputs 0 immediately; a late bellek_yanit_gecerli_i after release -> no sonuc_gecerli_o.

Source files
------------

// File: rtl/bellek_asamasi_pkg.sv
// Shared types and helpers for the kutu pipeline memory stage:
// funct3 codes, stage states, memory request payload and store lane helpers.
package kutu_paket;

  localparam int unsigned VERI_W = 32;
  localparam int unsigned MASKE_W = VERI_W / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    YANIT = 2'd2
  } durum_e;

  typedef struct packed {
    logic                yaz;
    logic [VERI_W-1:0]   adres;
    logic [MASKE_W-1:0]  maske;
    logic [VERI_W-1:0]   veri;
  } bellek_istek_t;

  // Width/alignment/opcode legality, evaluated on the accepting cycle.
  function automatic logic erisim_yasal(input logic       yukle,
                                        input logic       sakla,
                                        input logic [2:0] f3,
                                        input logic [1:0] ofset);
    logic yasal;
    yasal = 1'b0;
    if (yukle && !sakla) begin
      case (f3)
        F3_B, F3_BU: yasal = 1'b1;
        F3_H, F3_HU: yasal = ~ofset[0];
        F3_W:        yasal = (ofset == 2'b00);
        default:     yasal = 1'b0;
      endcase
    end else if (sakla && !yukle) begin
      case (f3)
        F3_B:    yasal = 1'b1;
        F3_H:    yasal = ~ofset[0];
        F3_W:    yasal = (ofset == 2'b00);
        default: yasal = 1'b0;
      endcase
    end
    return yasal;
  endfunction

  function automatic logic [MASKE_W-1:0] maske_hesapla(input logic [2:0] f3,
                                                       input logic [1:0] ofset);
    logic [MASKE_W-1:0] maske;
    case (f3)
      F3_B:    maske = 4'b0001 << ofset;
      F3_H:    maske = 4'b0011 << ofset;
      F3_W:    maske = 4'b1111;
      default: maske = '0;
    endcase
    return maske;
  endfunction

  function automatic logic [VERI_W-1:0] veri_cogalt(input logic [2:0]        f3,
                                                    input logic [VERI_W-1:0] veri);
    logic [VERI_W-1:0] sonuc;
    case (f3)
      F3_B:    sonuc = {4{veri[7:0]}};
      F3_H:    sonuc = {2{veri[15:0]}};
      default: sonuc = veri;
    endcase
    return sonuc;
  endfunction

endpackage

// File: rtl/bellek_asamasi_hizalayici.sv
// Load data aligner: picks the addressed byte/halfword lane of the read word
// and sign- or zero-extends it according to funct3.
module yukleme_hizalayici
  import kutu_paket::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        ofset_i,
  input  logic [VERI_W-1:0] kelime_i,
  output logic [VERI_W-1:0] sonuc_o
);

  logic [7:0]  bayt;
  logic [15:0] yarim;

  always_comb begin
    bayt = kelime_i[7:0];
    case (ofset_i)
      2'd0:    bayt = kelime_i[7:0];
      2'd1:    bayt = kelime_i[15:8];
      2'd2:    bayt = kelime_i[23:16];
      default: bayt = kelime_i[31:24];
    endcase
    yarim = ofset_i[1] ? kelime_i[31:16] : kelime_i[15:0];
  end

  always_comb begin
    sonuc_o = kelime_i;
    case (funct3_i)
      F3_B:    sonuc_o = {{24{bayt[7]}}, bayt};
      F3_BU:   sonuc_o = {24'd0, bayt};
      F3_H:    sonuc_o = {{16{yarim[15]}}, yarim};
      F3_HU:   sonuc_o = {16'd0, yarim};
      default: sonuc_o = kelime_i;
    endcase
  end

endmodule

// File: rtl/bellek_asamasi.sv
// Memory-access stage: one outstanding request/response to data memory,
// load alignment, upstream stall, and one-cycle pass-through for ALU results.
module bellek_asamasi
  import kutu_paket::*;
#(
  parameter int unsigned ZAMAN_ASIMI = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                gecerli_i,
  input  logic                yukle_i,
  input  logic                sakla_i,
  input  logic [2:0]          funct3_i,
  input  logic [VERI_W-1:0]   adres_i,
  input  logic [VERI_W-1:0]   veri_i,
  input  logic [4:0]          hedef_i,
  output logic                durdur_o,
  output logic                bellek_istek_o,
  input  logic                bellek_hazir_i,
  output logic                bellek_yaz_o,
  output logic [VERI_W-1:0]   bellek_adres_o,
  output logic [MASKE_W-1:0]  bellek_maske_o,
  output logic [VERI_W-1:0]   bellek_veri_o,
  input  logic                bellek_yanit_gecerli_i,
  input  logic [VERI_W-1:0]   bellek_veri_i,
  output logic                sonuc_gecerli_o,
  output logic [VERI_W-1:0]   sonuc_o,
  output logic [4:0]          hedef_o,
  output logic                hata_o
);

  localparam int unsigned SAYAC_W = (ZAMAN_ASIMI < 2) ? 1 : $clog2(ZAMAN_ASIMI + 1);

  durum_e              durum_q, durum_d;
  logic                durdur_q, durdur_d;
  logic                istek_q, istek_d;
  bellek_istek_t       yuk_q, yuk_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          ofset_q, ofset_d;
  logic [4:0]          rd_q, rd_d;
  logic [SAYAC_W-1:0]  sayac_q, sayac_d;
  logic                sonuc_gecerli_q, sonuc_gecerli_d;
  logic [VERI_W-1:0]   sonuc_q, sonuc_d;
  logic [4:0]          hedef_q, hedef_d;
  logic                hata_q, hata_d;

  logic [VERI_W-1:0]   hizali;
  logic                zaman_doldu;
  logic                bellek_islemi;

  yukleme_hizalayici u_hizalayici (
    .funct3_i (funct3_q),
    .ofset_i  (ofset_q),
    .kelime_i (bellek_veri_i),
    .sonuc_o  (hizali)
  );

  assign zaman_doldu   = (ZAMAN_ASIMI != 0) && (sayac_q == SAYAC_W'(ZAMAN_ASIMI));
  assign bellek_islemi = yukle_i | sakla_i;

  // Next-state and registered-output decode.
  always_comb begin
    durum_d         = durum_q;
    istek_d         = istek_q;
    yuk_d           = yuk_q;
    funct3_d        = funct3_q;
    ofset_d         = ofset_q;
    rd_d            = rd_q;
    sayac_d         = sayac_q;
    sonuc_gecerli_d = 1'b0;
    sonuc_d         = sonuc_q;
    hedef_d         = hedef_q;
    hata_d          = 1'b0;

    case (durum_q)
      BOSTA: begin
        if (gecerli_i) begin
          if (!bellek_islemi) begin
            sonuc_gecerli_d = 1'b1;
            sonuc_d         = adres_i;
            hedef_d         = hedef_i;
          end else if (erisim_yasal(yukle_i, sakla_i, funct3_i, adres_i[1:0])) begin
            durum_d     = ISTEK;
            istek_d     = 1'b1;
            yuk_d.yaz   = sakla_i;
            yuk_d.adres = {adres_i[VERI_W-1:2], 2'b00};
            yuk_d.maske = sakla_i ? maske_hesapla(funct3_i, adres_i[1:0]) : '0;
            yuk_d.veri  = sakla_i ? veri_cogalt(funct3_i, veri_i) : '0;
            funct3_d    = funct3_i;
            ofset_d     = adres_i[1:0];
            rd_d        = hedef_i;
            sayac_d     = '0;
          end else begin
            hata_d = 1'b1;
          end
        end
      end

      ISTEK: begin
        if (bellek_hazir_i) begin
          istek_d = 1'b0;
          yuk_d   = '0;
          durum_d = yuk_q.yaz ? BOSTA : YANIT;
        end else if (zaman_doldu) begin
          istek_d = 1'b0;
          yuk_d   = '0;
          hata_d  = 1'b1;
          durum_d = BOSTA;
        end
        if (ZAMAN_ASIMI != 0 && !zaman_doldu) sayac_d = sayac_q + SAYAC_W'(1);
      end

      YANIT: begin
        // A response in the limit cycle still completes the load.
        if (bellek_yanit_gecerli_i) begin
          sonuc_gecerli_d = 1'b1;
          sonuc_d         = hizali;
          hedef_d         = rd_q;
          durum_d         = BOSTA;
        end else if (zaman_doldu) begin
          hata_d  = 1'b1;
          durum_d = BOSTA;
        end
        if (ZAMAN_ASIMI != 0 && !zaman_doldu) sayac_d = sayac_q + SAYAC_W'(1);
      end

      default: begin
        durum_d = BOSTA;
        istek_d = 1'b0;
        yuk_d   = '0;
      end
    endcase

    durdur_d = (durum_d != BOSTA);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q         <= BOSTA;
      durdur_q        <= 1'b0;
      istek_q         <= 1'b0;
      yuk_q           <= '0;
      funct3_q        <= '0;
      ofset_q         <= '0;
      rd_q            <= '0;
      sayac_q         <= '0;
      sonuc_gecerli_q <= 1'b0;
      sonuc_q         <= '0;
      hedef_q         <= '0;
      hata_q          <= 1'b0;
    end else begin
      durum_q         <= durum_d;
      durdur_q        <= durdur_d;
      istek_q         <= istek_d;
      yuk_q           <= yuk_d;
      funct3_q        <= funct3_d;
      ofset_q         <= ofset_d;
      rd_q            <= rd_d;
      sayac_q         <= sayac_d;
      sonuc_gecerli_q <= sonuc_gecerli_d;
      sonuc_q         <= sonuc_d;
      hedef_q         <= hedef_d;
      hata_q          <= hata_d;
    end
  end

  assign durdur_o        = durdur_q;
  assign bellek_istek_o  = istek_q;
  assign bellek_yaz_o    = yuk_q.yaz;
  assign bellek_adres_o  = yuk_q.adres;
  assign bellek_maske_o  = yuk_q.maske;
  assign bellek_veri_o   = yuk_q.veri;
  assign sonuc_gecerli_o = sonuc_gecerli_q;
  assign sonuc_o         = sonuc_q;
  assign hedef_o         = hedef_q;
  assign hata_o          = hata_q;

endmodule

// File: tb/tb_bellek_asamasi.sv
// Self-checking bench for bellek_asamasi: table of single transactions plus
// hand-written timeout, slow-ready and reset-in-flight sequences.
module tb_bellek_asamasi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        gecerli_i, yukle_i, sakla_i;
  logic [2:0]  funct3_i;
  logic [31:0] adres_i, veri_i;
  logic [4:0]  hedef_i;
  logic        durdur_o, bellek_istek_o, bellek_hazir_i, bellek_yaz_o;
  logic [31:0] bellek_adres_o, bellek_veri_o;
  logic [3:0]  bellek_maske_o;
  logic        bellek_yanit_gecerli_i;
  logic [31:0] bellek_veri_i;
  logic        sonuc_gecerli_o;
  logic [31:0] sonuc_o;
  logic [4:0]  hedef_o;
  logic        hata_o;

  int n_kontrol = 0;
  int n_hata    = 0;

  bellek_asamasi #(.ZAMAN_ASIMI(4)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .gecerli_i              (gecerli_i),
    .yukle_i                (yukle_i),
    .sakla_i                (sakla_i),
    .funct3_i               (funct3_i),
    .adres_i                (adres_i),
    .veri_i                 (veri_i),
    .hedef_i                (hedef_i),
    .durdur_o               (durdur_o),
    .bellek_istek_o         (bellek_istek_o),
    .bellek_hazir_i         (bellek_hazir_i),
    .bellek_yaz_o           (bellek_yaz_o),
    .bellek_adres_o         (bellek_adres_o),
    .bellek_maske_o         (bellek_maske_o),
    .bellek_veri_o          (bellek_veri_o),
    .bellek_yanit_gecerli_i (bellek_yanit_gecerli_i),
    .bellek_veri_i          (bellek_veri_i),
    .sonuc_gecerli_o        (sonuc_gecerli_o),
    .sonuc_o                (sonuc_o),
    .hedef_o                (hedef_o),
    .hata_o                 (hata_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        yukle;
    logic        sakla;
    logic [2:0]  f3;
    logic [31:0] adres;
    logic [31:0] veri;
    logic [4:0]  hedef;
    logic [31:0] okuma;
    logic        bek_hata;
    logic [31:0] bek_sonuc;
    logic [3:0]  bek_maske;
    logic [31:0] bek_bveri;
  } vektor_t;

  vektor_t v[15];

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    n_kontrol++;
    if (gercek !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", ad, gercek, beklenen);
    end
  endtask

  task automatic bosta_gir();
    gecerli_i = 1'b0; yukle_i = 1'b0; sakla_i = 1'b0; funct3_i = '0;
    adres_i = '0; veri_i = '0; hedef_i = '0;
  endtask

  task automatic adim();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cikislar_sifir(input string ad);
    kontrol({ad, " durdur"}, 32'(durdur_o), 32'd0);
    kontrol({ad, " istek"}, 32'(bellek_istek_o), 32'd0);
    kontrol({ad, " yaz"}, 32'(bellek_yaz_o), 32'd0);
    kontrol({ad, " badres"}, bellek_adres_o, 32'd0);
    kontrol({ad, " maske"}, 32'(bellek_maske_o), 32'd0);
    kontrol({ad, " bveri"}, bellek_veri_o, 32'd0);
    kontrol({ad, " sonuc_gecerli"}, 32'(sonuc_gecerli_o), 32'd0);
    kontrol({ad, " sonuc"}, sonuc_o, 32'd0);
    kontrol({ad, " hedef"}, 32'(hedef_o), 32'd0);
    kontrol({ad, " hata"}, 32'(hata_o), 32'd0);
  endtask

  // One table entry: immediate hazir, response one cycle after acceptance.
  task automatic yurut(input int i, input vektor_t t);
    string ad;
    ad = $sformatf("v%0d", i);
    gecerli_i = 1'b1; yukle_i = t.yukle; sakla_i = t.sakla; funct3_i = t.f3;
    adres_i = t.adres; veri_i = t.veri; hedef_i = t.hedef;
    kontrol({ad, " T0 durdur"}, 32'(durdur_o), 32'd0);
    adim();
    bosta_gir();
    if (t.bek_hata) begin
      kontrol({ad, " hata"}, 32'(hata_o), 32'd1);
      kontrol({ad, " istek"}, 32'(bellek_istek_o), 32'd0);
      kontrol({ad, " sonuc_gecerli"}, 32'(sonuc_gecerli_o), 32'd0);
      adim();
      kontrol({ad, " hata pulse"}, 32'(hata_o), 32'd0);
    end else if (!t.yukle && !t.sakla) begin
      kontrol({ad, " sonuc_gecerli"}, 32'(sonuc_gecerli_o), 32'd1);
      kontrol({ad, " sonuc"}, sonuc_o, t.bek_sonuc);
      kontrol({ad, " hedef"}, 32'(hedef_o), 32'(t.hedef));
      kontrol({ad, " durdur"}, 32'(durdur_o), 32'd0);
      kontrol({ad, " istek"}, 32'(bellek_istek_o), 32'd0);
      adim();
    end else begin
      kontrol({ad, " T1 istek"}, 32'(bellek_istek_o), 32'd1);
      kontrol({ad, " T1 durdur"}, 32'(durdur_o), 32'd1);
      kontrol({ad, " badres"}, bellek_adres_o, {t.adres[31:2], 2'b00});
      kontrol({ad, " yaz"}, 32'(bellek_yaz_o), 32'(t.sakla));
      kontrol({ad, " maske"}, 32'(bellek_maske_o), 32'(t.bek_maske));
      if (t.sakla) kontrol({ad, " bveri"}, bellek_veri_o, t.bek_bveri);
      bellek_hazir_i = 1'b1;
      adim();
      bellek_hazir_i = 1'b0;
      kontrol({ad, " T2 istek"}, 32'(bellek_istek_o), 32'd0);
      if (t.sakla) begin
        kontrol({ad, " T2 durdur"}, 32'(durdur_o), 32'd0);
        kontrol({ad, " T2 sonuc_gecerli"}, 32'(sonuc_gecerli_o), 32'd0);
        adim();
        kontrol({ad, " T3 sonuc_gecerli"}, 32'(sonuc_gecerli_o), 32'd0);
      end else begin
        kontrol({ad, " T2 durdur"}, 32'(durdur_o), 32'd1);
        bellek_yanit_gecerli_i = 1'b1;
        bellek_veri_i = t.okuma;
        adim();
        bellek_yanit_gecerli_i = 1'b0;
        bellek_veri_i = '0;
        kontrol({ad, " T3 sonuc_gecerli"}, 32'(sonuc_gecerli_o), 32'd1);
        kontrol({ad, " T3 sonuc"}, sonuc_o, t.bek_sonuc);
        kontrol({ad, " T3 hedef"}, 32'(hedef_o), 32'(t.hedef));
        kontrol({ad, " T3 durdur"}, 32'(durdur_o), 32'd0);
        adim();
        kontrol({ad, " T4 sonuc_gecerli"}, 32'(sonuc_gecerli_o), 32'd0);
      end
    end
  endtask

  initial begin
    int n;
    //            yk  sk  f3      adres         veri          rd  okuma         hata sonuc         maske    bveri
    v[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        5'd5, 32'h0,        1'b0, 32'h0000_1234, 4'b0000, 32'h0};
    v[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd7, 32'h80FF_0000, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0};
    v[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        5'd8, 32'h80FF_0000, 1'b0, 32'h0000_0080, 4'b0000, 32'h0};
    v[3]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        5'd9, 32'h80FF_0000, 1'b0, 32'hFFFF_80FF, 4'b0000, 32'h0};
    v[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        5'd10, 32'h1234_F00D, 1'b0, 32'h0000_F00D, 4'b0000, 32'h0};
    v[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,        5'd0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0};
    v[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd3, 32'h0,        1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF};
    v[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_5678, 5'd4, 32'h0,        1'b0, 32'h0,         4'b0010, 32'h7878_7878};
    v[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 5'd6, 32'h0,        1'b0, 32'h0,         4'b1111, 32'hCAFE_F00D};
    v[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        5'd1, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0};
    v[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_0008, 32'h0,        5'd1, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0};
    v[11] = '{1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h1111,     5'd1, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0};
    v[12] = '{1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h0,        5'd1, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0};
    v[13] = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        5'd1, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0};
    v[14] = '{1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,        5'd11, 32'h0055_0000, 1'b0, 32'h0000_0055, 4'b0000, 32'h0};

    bosta_gir();
    bellek_hazir_i = 1'b0;
    bellek_yanit_gecerli_i = 1'b0;
    bellek_veri_i = '0;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    cikislar_sifir("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    adim();

    for (int i = 0; i < 15; i++) yurut(i, v[i]);

    // Memory never ready: abort after the counter reaches 4.
    gecerli_i = 1'b1; yukle_i = 1'b1; funct3_i = 3'b010; adres_i = 32'h20; hedef_i = 5'd2;
    adim();
    bosta_gir();
    kontrol("zaman T1 istek", 32'(bellek_istek_o), 32'd1);
    n = 0;
    while (!hata_o && n < 20) begin
      adim();
      n++;
    end
    kontrol("zaman hata cycle", 32'(n), 32'd5);
    kontrol("zaman istek dropped", 32'(bellek_istek_o), 32'd0);
    kontrol("zaman durdur", 32'(durdur_o), 32'd0);
    kontrol("zaman sonuc_gecerli", 32'(sonuc_gecerli_o), 32'd0);
    adim();
    kontrol("zaman hata pulse", 32'(hata_o), 32'd0);

    // Ready after three idle cycles: normal completion.
    gecerli_i = 1'b1; yukle_i = 1'b1; funct3_i = 3'b010; adres_i = 32'h24; hedef_i = 5'd12;
    adim();
    bosta_gir();
    repeat (3) adim();
    kontrol("yavas istek held", 32'(bellek_istek_o), 32'd1);
    kontrol("yavas badres stable", bellek_adres_o, 32'h24);
    bellek_hazir_i = 1'b1;
    adim();
    bellek_hazir_i = 1'b0;
    bellek_yanit_gecerli_i = 1'b1;
    bellek_veri_i = 32'h0BAD_F00D;
    adim();
    bellek_yanit_gecerli_i = 1'b0;
    kontrol("yavas hata", 32'(hata_o), 32'd0);
    kontrol("yavas sonuc_gecerli", 32'(sonuc_gecerli_o), 32'd1);
    kontrol("yavas sonuc", sonuc_o, 32'h0BAD_F00D);
    kontrol("yavas hedef", 32'(hedef_o), 32'd12);
    adim();

    // Reset while waiting for a response; a late response must be dropped.
    gecerli_i = 1'b1; yukle_i = 1'b1; funct3_i = 3'b010; adres_i = 32'h40; hedef_i = 5'd13;
    adim();
    bosta_gir();
    bellek_hazir_i = 1'b1;
    adim();
    bellek_hazir_i = 1'b0;
    kontrol("rst pre durdur", 32'(durdur_o), 32'd1);
    rst_i = 1'b0;
    #1;
    cikislar_sifir("rst async");
    @(negedge clk_i);
    rst_i = 1'b1;
    adim();
    bellek_yanit_gecerli_i = 1'b1;
    bellek_veri_i = 32'h5555_AAAA;
    adim();
    bellek_yanit_gecerli_i = 1'b0;
    kontrol("gec yanit sonuc_gecerli", 32'(sonuc_gecerli_o), 32'd0);
    kontrol("gec yanit durdur", 32'(durdur_o), 32'd0);
    adim();
    kontrol("gec yanit sonuc_gecerli 2", 32'(sonuc_gecerli_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
    $finish;
  end

endmodule
